clock_divider_prog: RTL
=======================

Name: clock_divider_prog

Overview:
Runtime-programmable successor to the fixed-ratio clock divider. It generates a divided clock with a selectable idle polarity. It also produces single-cycle rise/fall strobes for the SSD1331 SPI serialiser and accepts glitch-free divisor changes at period boundaries. One instance feeds SCLK generation; further instances serve as slow timers (reset delay, frame pacing).

Parameters:
CNT_W, 16, width of divisor and internal counter
DEFAULT_DIV, 100, divisor loaded at reset; must be >= 2 and < 2**CNT_W

Ports:
i_CLK  input  1  system clock
i_RST  input  1  asynchronous active-high reset
i_EN  input  1  run enable; low forces idle
i_CPOL  input  1  idle level of o_CLK_DIV; sampled only in IDLE
i_DIV  input  CNT_W  requested divisor (period in i_CLK cycles)
i_DIV_LD  input  1  one-cycle strobe capturing i_DIV
o_CLK_DIV  output  1  divided clock, registered
o_RISE  output  1  one-cycle pulse, high in the cycle o_CLK_DIV becomes 1
o_FALL  output  1  one-cycle pulse, high in the cycle o_CLK_DIV becomes 0
o_DIV_ACK  output  1  one-cycle pulse when the pending divisor becomes active
o_BUSY  output  1  high while not in IDLE

Behaviour:
- Clocking and reset: one clock, i_CLK; reset is asynchronous and active-high on i_RST.
- Reset values: state=IDLE, counter=0, active divisor D=DEFAULT_DIV, pending flag=0, latched polarity=0, all outputs 0.
- Divisor clamp: on capture, D values 0 and 1 clamp to 2. Odd values are legal.
- Phase lengths: phase A (level = latched CPOL) lasts ceil(D/2) cycles; phase B (level = ~CPOL) lasts floor(D/2) cycles. Period = D cycles exactly.
- States:
  - IDLE: o_CLK_DIV = i_CPOL (registered, 1-cycle lag); counter=0. On i_EN=1, latch CPOL and go to RUN_A.
  - RUN_A: counter increments. At counter == ceil(D/2)-1, toggle the output, reset the counter, go to RUN_B.
  - RUN_B: counter increments. At counter == floor(D/2)-1, toggle the output, reset the counter, go to RUN_A. This is the period boundary.
- Disable: i_EN=0 in any RUN state → next edge goes to IDLE with counter=0 and o_CLK_DIV=CPOL. If this changes the level, the matching strobe still fires. No partial-phase completion.
- First edge after enable: ceil(D/2) cycles after the first cycle in which i_EN is sampled high.
- Strobes: registered and coincident with the o_CLK_DIV transition. o_RISE and o_FALL are never both high.
- Divisor load:
  - i_DIV_LD stores the clamped i_DIV as pending and sets the pending flag.
  - In IDLE, or when i_EN=0, the pending value applies on the next edge.
  - Otherwise it applies at the period boundary (RUN_B→RUN_A transition). The new D governs the following RUN_A.
  - o_DIV_ACK pulses in the cycle D updates.
  - A second i_DIV_LD before application overwrites pending; one ACK only.
  - i_DIV_LD in the same cycle as a boundary: the boundary applies the old pending value if set; the new value becomes pending.
- CPOL change while running: ignored until the next IDLE.
- Counter width: CNT_W bits; no wrap is possible because the counter compares against at most ceil((2**CNT_W-1)/2).

Optional Feature:
CLKDIV_BURST_EN:
- Adds i_BURST_LEN [7:0], i_BURST_GO (strobe) and o_DONE.
- With it: i_BURST_GO in IDLE runs exactly i_BURST_LEN full periods regardless of i_EN. After the final RUN_B→RUN_A boundary it returns to IDLE and pulses o_DONE for one cycle.
  - i_BURST_LEN=0: o_DONE the next cycle, no edges.
  - i_EN=0 does not abort a burst; i_RST does.
- Without it: ports absent; the block is free-running under i_EN only.

Decomposition:
- Package clkdiv_pkg: state encoding (IDLE, RUN_A, RUN_B as 2-bit constants), MIN_DIV=2, default CNT_W.
- No sub-module: a single always block for the state/counter plus one for the divisor shadow is natural. The burst counter stays inline under the macro.

Test Plan:
- Reset mid-run: assert i_RST while in RUN_B with D=10 → outputs 0, state IDLE, D=DEFAULT_DIV immediately (asynchronous).
- Odd divisor: D=5, CPOL=0, i_EN=1 → low 3 cycles, high 2 cycles; period 5. o_RISE every 5 cycles; o_FALL 2 cycles after each o_RISE.
- Divisor change while running: D=8, load i_DIV=4 mid RUN_A → current period completes with 8. o_DIV_ACK at the boundary; next period is 4 (2 low, 2 high).
- Clamp and double-load: load 0, then 1 the next cycle while running → single o_DIV_ACK; D=2; output toggles every cycle.
- CPOL=1, D=6: idle high; after enable, high 3 cycles then low 3. o_FALL first; i_CPOL change to 0 while running has no effect. Disable returns idle high.
- Burst (CLKDIV_BURST_EN): D=4, i_BURST_LEN=3, i_BURST_GO → exactly 3 o_RISE pulses, then o_DONE 1 cycle after the third boundary. o_BUSY falls with the return to IDLE.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
package clkdiv_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2
  } cd_state_e;

endpackage

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with CPOL, edge strobes and shadowed divisor.
// Optional burst mode is enabled by defining CLKDIV_BURST_EN.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_EN,
  input  logic             i_CPOL,
  input  logic [CNT_W-1:0] i_DIV,
  input  logic             i_DIV_LD,
  output logic             o_CLK_DIV,
  output logic             o_RISE,
  output logic             o_FALL,
  output logic             o_DIV_ACK,
`ifdef CLKDIV_BURST_EN
  input  logic [7:0]       i_BURST_LEN,
  input  logic             i_BURST_GO,
  output logic             o_DONE,
`endif
  output logic             o_BUSY
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  cd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pvld_q, pvld_d;
  logic             cpol_q, cpol_d;
  logic             clk_q, clk_d;
  logic             rise_q, fall_q, ack_q, ack_d;

  logic [CNT_W-1:0] half_a, half_b, div_clamp;
  logic             run_en, start_w, last_w, boundary, apply;

  assign half_a    = (div_q >> 1) + CNT_W'(div_q[0]);
  assign half_b    = div_q >> 1;
  assign div_clamp = (i_DIV < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : i_DIV;

`ifdef CLKDIV_BURST_EN
  logic       burst_q, burst_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       done_q, done_d;

  assign run_en  = i_EN | burst_q;
  assign start_w = i_EN | (i_BURST_GO & (i_BURST_LEN != 8'd0));
  assign last_w  = burst_q & (bcnt_q == 8'd1);

  always_comb begin
    burst_d = burst_q;
    bcnt_d  = bcnt_q;
    done_d  = 1'b0;
    if (state_q == IDLE && i_BURST_GO) begin
      if (i_BURST_LEN == 8'd0) begin
        done_d = 1'b1;
      end else begin
        burst_d = 1'b1;
        bcnt_d  = i_BURST_LEN;
      end
    end else if (boundary && burst_q) begin
      bcnt_d = bcnt_q - 8'd1;
      if (bcnt_q == 8'd1) begin
        burst_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      burst_q <= 1'b0;
      bcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
    end
  end

  assign o_DONE = done_q;
`else
  assign run_en  = i_EN;
  assign start_w = i_EN;
  assign last_w  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cpol_d   = cpol_q;
    clk_d    = clk_q;
    boundary = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = i_CPOL;
        if (start_w) begin
          cpol_d  = i_CPOL;
          state_d = RUN_A;
        end
      end
      RUN_A: begin
        if (!run_en) begin
          state_d = IDLE;
          cnt_d   = '0;
          clk_d   = cpol_q;
        end else if (cnt_q == half_a - ONE) begin
          state_d = RUN_B;
          cnt_d   = '0;
          clk_d   = ~clk_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RUN_B: begin
        if (!run_en) begin
          state_d = IDLE;
          cnt_d   = '0;
          clk_d   = cpol_q;
        end else if (cnt_q == half_b - ONE) begin
          boundary = 1'b1;
          state_d  = last_w ? IDLE : RUN_A;
          cnt_d    = '0;
          clk_d    = ~clk_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow divisor: old pending value wins over a same-cycle reload
  assign apply = pvld_q & ((state_q == IDLE) | ~run_en | boundary);

  always_comb begin
    div_d  = div_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    ack_d  = 1'b0;
    if (apply) begin
      div_d  = pend_q;
      pvld_d = 1'b0;
      ack_d  = 1'b1;
    end
    if (i_DIV_LD) begin
      pend_d = div_clamp;
      pvld_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= CNT_W'(DEFAULT_DIV);
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      cpol_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      cpol_q  <= cpol_d;
      clk_q   <= clk_d;
      rise_q  <= clk_d & ~clk_q;
      fall_q  <= ~clk_d & clk_q;
      ack_q   <= ack_d;
    end
  end

  assign o_CLK_DIV = clk_q;
  assign o_RISE    = rise_q;
  assign o_FALL    = fall_q;
  assign o_DIV_ACK = ack_q;
  assign o_BUSY    = (state_q != IDLE);

endmodule
